pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised next-PC sequencer for the single-cycle processor datapath. It replaces the discrete PC register, the +1 adder and the PCSrc/Jump/Jal/Jr mux chain with one block. It adds PC width and reset-vector parameters, a step enable, and a hardware return-address stack so `jal`/`ret` nest without a link register. It sits between the control unit / ULA zero flag and the instruction ROM address.

## Interface
Parameters:
- `N`, default 8: PC / address width in bits.
- `DEPTH`, default 4: return-stack entries (≥1).
- `RESET_PC`, default 0: PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `en`  in  1  step enable (slow-clock tick); when 0, all state holds.
- `imm`  in  N  branch offset (two's complement) or absolute jump target.
- `rs_val`  in  N  register value used as the `jr` target.
- `branch`  in  1  branch instruction.
- `zero`  in  1  ULA Z flag.
- `jump`  in  1  absolute jump to `imm`.
- `jal`  in  1  jump to `imm` and push the return address.
- `jr`  in  1  jump to `rs_val`.
- `ret`  in  1  pop the return stack and jump to the popped address.
- `pc`  out  N  current PC (ROM address).
- `pc_plus1`  out  N  `pc+1` mod 2^N, combinational.
- `sp`  out  $clog2(DEPTH+1)  number of valid stack entries.
- `ovf`  out  1  sticky flag: a push was attempted while the stack was full.
- `unf`  out  1  sticky flag: a pop was attempted while the stack was empty.

## Operation
- Stack: `DEPTH` registers of N bits; `sp` counts the valid entries; the top of stack is `stack[sp-1]`.
- Next-PC selection applies only when `en=1`. Priority, highest first:
  1. `jr`: next PC = `rs_val`. No stack effect.
  2. `ret` with `sp>0`: next PC = `stack[sp-1]`; `sp` decrements.
  3. `ret` with `sp==0`: set `unf`; next PC = `pc_plus1`.
  4. `jal`: next PC = `imm`. If `sp<DEPTH`, write `pc_plus1` to `stack[sp]` and increment `sp`. Otherwise set `ovf`, leave `sp` and the stack contents unchanged, and still take the jump.
  5. `jump`: next PC = `imm`.
  6. `branch & zero`: next PC = `pc_plus1 + imm` mod 2^N, with `imm` sign-extended to N bits (already N bits wide, so the add wraps).
  7. Otherwise: next PC = `pc_plus1`.
- Lower-priority requests asserted in the same cycle as a higher one are ignored completely. For example, `jal` is ignored when `ret` wins, so there is never a push and a pop in the same cycle.
- All arithmetic is modulo 2^N: `pc=2^N-1` steps to 0.
- `ovf` and `unf` are sticky. Only `rst` clears them.
- `en=0`: `pc`, `sp`, the stack and the flags all hold, whatever the control inputs are.

## Timing
- Reset (asynchronous, takes effect immediately on `rst` rising, even mid-cycle and even with `en=1`): `pc=RESET_PC`, `sp=0`, `ovf=0`, `unf=0`, all stack entries 0. `pc_plus1` then reads `RESET_PC+1`.
- While `rst=1`, no state changes. The first update happens at the first rising `clk` edge with `rst=0` and `en=1`.
- Latency: control inputs sampled at edge k determine `pc` after edge k, with one cycle of latency. `sp` and the stack update on the same edge.
- `pc_plus1` is combinational from `pc`, with zero latency.
- All control inputs are single-cycle level-sampled. There is no handshake; the caller holds them stable around the enabled edge.

## Test plan
- Reset mid-run: with `pc=0x2A`, `sp=2`, `ovf=1`, assert `rst` between clock edges -> `pc=0x00`, `sp=0` and `ovf=unf=0` immediately, before the next edge; `pc_plus1=0x01`.
- Wrap and enable: `pc=0xFF`, no control, `en=1`, then one edge -> `pc=0x00`. With `en=0`, `jump=1`, `imm=0x40`, three edges -> `pc` holds at 0x00.
- Branch: `pc=0x10`, `branch=1`, `imm=0xFC` (-4). With `zero=1` -> `pc=0x0D`. Repeat from `pc=0x10` with `zero=0` -> `pc=0x11`.
- Nested call/return: `pc=0x05`, `jal`, `imm=0x20` -> `pc=0x20`, `sp=1`. At 0x20, `jal`, `imm=0x30` -> `pc=0x30`, `sp=2`. First `ret` -> `pc=0x21`, `sp=1`. Second `ret` -> `pc=0x06`, `sp=0`.
- Overflow/underflow (`DEPTH=4`): five consecutive `jal` from PCs 0x01, 0x11, 0x21, 0x31 and 0x41 -> after the fifth, `sp=4`, `ovf=1`, and `pc` equals the fifth target. Four `ret` -> `pc` = 0x32, 0x22, 0x12, 0x02 in that order. A fifth `ret` at `pc=0x02` -> `unf=1`, `pc=0x03`, `sp=0`.
- Priority: `sp=1` with top entry 0x06; assert `jr=1`, `ret=1`, `jal=1`, `rs_val=0x77` -> `pc=0x77`, `sp=1`, top entry still 0x06. Next, assert `ret=1` and `jal=1` together -> `pc=0x06`, `sp=0`, no push.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC selection and a hardware return-address stack
// for the single-cycle datapath. Priority: jr > ret > jal > jump > taken branch > pc+1.
module pc_sequencer #(
   parameter int unsigned N        = 8,
   parameter int unsigned DEPTH    = 4,
   parameter logic [N-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [N-1:0]               imm,
   input  logic [N-1:0]               rs_val,
   input  logic                       branch,
   input  logic                       zero,
   input  logic                       jump,
   input  logic                       jal,
   input  logic                       jr,
   input  logic                       ret,
   output logic [N-1:0]               pc,
   output logic [N-1:0]               pc_plus1,
   output logic [$clog2(DEPTH+1)-1:0] sp,
   output logic                       ovf,
   output logic                       unf
);

   localparam int unsigned SPW = $clog2(DEPTH + 1);

   logic [N-1:0]   pc_q, pc_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic           ovf_q, ovf_d;
   logic           unf_q, unf_d;
   logic [N-1:0]   stack_q [DEPTH];
   logic [N-1:0]   stack_d [DEPTH];
   logic [N-1:0]   top;
   logic           push;

   assign pc       = pc_q;
   assign pc_plus1 = pc_q + N'(1);
   assign sp       = sp_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

   // Select stack[sp-1]; yields 0 when the stack is empty (never used then).
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (SPW'(i) == sp_q - SPW'(1)) begin
            top = stack_q[i];
         end
      end
   end

   // Next-state selection; everything holds unless en is high.
   always_comb begin
      pc_d    = pc_q;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      stack_d = stack_q;
      if (en) begin
         if (jr) begin
            pc_d = rs_val;
         end else if (ret) begin
            if (sp_q != '0) begin
               pc_d = top;
               sp_d = sp_q - SPW'(1);
            end else begin
               unf_d = 1'b1;
               pc_d  = pc_plus1;
            end
         end else if (jal) begin
            pc_d = imm;
            if (sp_q < SPW'(DEPTH)) begin
               push = 1'b1;
               sp_d = sp_q + SPW'(1);
            end else begin
               // Full stack: flag it, keep contents, still take the call.
               ovf_d = 1'b1;
            end
         end else if (jump) begin
            pc_d = imm;
         end else if (branch && zero) begin
            pc_d = pc_plus1 + imm;
         end else begin
            pc_d = pc_plus1;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (SPW'(i) == sp_q)) begin
            stack_d[i] = pc_plus1;
         end
      end
   end

   // State registers with asynchronous active-high reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (N=8, DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] imm, rs_val;
   logic       branch, zero, jump, jal, jr, ret;
   logic [7:0] pc, pc_plus1;
   logic [2:0] sp;
   logic       ovf, unf;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.N(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .imm      (imm),
      .rs_val   (rs_val),
      .branch   (branch),
      .zero     (zero),
      .jump     (jump),
      .jal      (jal),
      .jr       (jr),
      .ret      (ret),
      .pc       (pc),
      .pc_plus1 (pc_plus1),
      .sp       (sp),
      .ovf      (ovf),
      .unf      (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, sample 1 time unit later, then drop all control requests.
   task automatic tick();
      @(posedge clk);
      #1;
      branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; ret = 1'b0;
   endtask

   task automatic go(input logic [7:0] target);
      jump = 1'b1; imm = target;
      tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; imm = '0; rs_val = '0;
      branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; ret = 1'b0;
      #12;
      check("reset_pc", pc, 8'h00);
      check("reset_pc_plus1", pc_plus1, 8'h01);
      check("reset_sp", sp, 3'd0);
      check("reset_ovf", ovf, 1'b0);
      check("reset_unf", unf, 1'b0);
      rst = 1'b0;
      tick();
      check("first_step", pc, 8'h01);

      // Wrap and enable
      go(8'hFF);
      check("pc_ff", pc, 8'hFF);
      check("pc_plus1_wrap", pc_plus1, 8'h00);
      tick();
      check("wrap_to_0", pc, 8'h00);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         jump = 1'b1; imm = 8'h40;
         tick();
      end
      check("en0_hold_pc", pc, 8'h00);
      en = 1'b1;

      // Branch
      go(8'h10);
      branch = 1'b1; zero = 1'b1; imm = 8'hFC;
      tick();
      check("branch_taken", pc, 8'h0D);
      go(8'h10);
      branch = 1'b1; zero = 1'b0; imm = 8'hFC;
      tick();
      check("branch_not_taken", pc, 8'h11);

      // Nested call/return
      go(8'h05);
      jal = 1'b1; imm = 8'h20; tick();
      check("call1_pc", pc, 8'h20);
      check("call1_sp", sp, 3'd1);
      jal = 1'b1; imm = 8'h30; tick();
      check("call2_pc", pc, 8'h30);
      check("call2_sp", sp, 3'd2);
      ret = 1'b1; tick();
      check("ret1_pc", pc, 8'h21);
      check("ret1_sp", sp, 3'd1);
      ret = 1'b1; tick();
      check("ret2_pc", pc, 8'h06);
      check("ret2_sp", sp, 3'd0);

      // Priority
      go(8'h05);
      jal = 1'b1; imm = 8'h20; tick();
      check("prio_setup_sp", sp, 3'd1);
      jr = 1'b1; ret = 1'b1; jal = 1'b1; rs_val = 8'h77; imm = 8'h50; tick();
      check("prio_jr_pc", pc, 8'h77);
      check("prio_jr_sp", sp, 3'd1);
      en = 1'b0; ret = 1'b1; tick();
      check("en0_ret_pc", pc, 8'h77);
      check("en0_ret_sp", sp, 3'd1);
      en = 1'b1;
      ret = 1'b1; jal = 1'b1; imm = 8'h50; tick();
      check("prio_ret_pc", pc, 8'h06);
      check("prio_ret_sp", sp, 3'd0);
      check("prio_no_flags", {ovf, unf}, 2'b00);

      // Overflow / underflow
      go(8'h01);
      jal = 1'b1; imm = 8'h11; tick();
      jal = 1'b1; imm = 8'h21; tick();
      jal = 1'b1; imm = 8'h31; tick();
      jal = 1'b1; imm = 8'h41; tick();
      check("full_sp", sp, 3'd4);
      check("full_no_ovf", ovf, 1'b0);
      jal = 1'b1; imm = 8'h55; tick();
      check("ovf_pc", pc, 8'h55);
      check("ovf_sp", sp, 3'd4);
      check("ovf_flag", ovf, 1'b1);
      ret = 1'b1; tick(); check("pop4", pc, 8'h32);
      ret = 1'b1; tick(); check("pop3", pc, 8'h22);
      ret = 1'b1; tick(); check("pop2", pc, 8'h12);
      ret = 1'b1; tick(); check("pop1", pc, 8'h02);
      check("empty_no_unf", unf, 1'b0);
      ret = 1'b1; tick();
      check("unf_pc", pc, 8'h03);
      check("unf_sp", sp, 3'd0);
      check("unf_flag", unf, 1'b1);
      check("ovf_sticky", ovf, 1'b1);

      // Reset mid-run
      jal = 1'b1; imm = 8'h10; tick();
      jal = 1'b1; imm = 8'h2A; tick();
      check("pre_rst_pc", pc, 8'h2A);
      check("pre_rst_sp", sp, 3'd2);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_pc", pc, 8'h00);
      check("async_rst_pc_plus1", pc_plus1, 8'h01);
      check("async_rst_sp", sp, 3'd0);
      check("async_rst_flags", {ovf, unf}, 2'b00);
      jump = 1'b1; imm = 8'h40;
      tick();
      check("rst_held_pc", pc, 8'h00);
      rst = 1'b0;
      ret = 1'b1; tick();
      check("post_rst_unf", unf, 1'b1);
      check("post_rst_pc", pc, 8'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
